// File: rtl/symbol_upsampler.sv
`default_nettype none
// ============================================================================
//  Module      : symbol_upsampler
//  Description : Test-stimulus source for the brick-wall FIR. Builds a
//                4-level PAM symbol stream from a 15-bit PRBS (Gray mapped)
//                and upsamples it by zero insertion. Debug modes provide an
//                impulse train, DC and an alternating +/-3a pattern.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    CLK_PER_SAMP : clocks per output sample (>= 1)
//    SPS          : samples per symbol / upsample factor (>= 2)
//    AMP          : inner level a in 1s17; outer level is 3*AMP (<= 131071)
//  Ports
//    clk          : in  1      system clock, rising edge
//    reset        : in  1      synchronous, active-high
//    mode         : in  2      0 PRBS 4-ASK, 1 impulse, 2 DC, 3 alternating
//    x_out        : out 18 s   registered sample for the FIR x_in
//    sample_valid : out 1      one-clock pulse whenever x_out is updated
//    sym_strobe   : out 1      high with sample_valid on phase-0 samples
//    sym_bits     : out 2      LFSR bits behind the current symbol
// ============================================================================
module symbol_upsampler #(
    parameter int                 CLK_PER_SAMP = 1,
    parameter int                 SPS          = 4,
    parameter logic signed [17:0] AMP          = 18'sd21845
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [1:0]         mode,
    output logic signed [17:0] x_out,
    output logic               sample_valid,
    output logic               sym_strobe,
    output logic [1:0]         sym_bits
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam int DIV_W = (CLK_PER_SAMP > 1) ? $clog2(CLK_PER_SAMP) : 1;
    localparam int PH_W  = $clog2(SPS);

    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_PER_SAMP - 1);
    localparam logic [PH_W-1:0]  PH_MAX  = PH_W'(SPS - 1);

    // Levels are fixed at elaboration; 3*AMP is required to fit in 1s17,
    // so no saturation logic is needed at run time.
    localparam logic signed [17:0] POS_A   = AMP;
    localparam logic signed [17:0] NEG_A   = 18'(-int'(AMP));
    localparam logic signed [17:0] POS_3A  = 18'(3 * int'(AMP));
    localparam logic signed [17:0] NEG_3A  = 18'(-3 * int'(AMP));
    localparam logic signed [17:0] FULL    = 18'sd131071;
    localparam logic signed [17:0] ZERO    = 18'sd0;

    localparam logic [14:0] LFSR_SEED = 15'h0001;

    localparam logic [1:0] MODE_PRBS    = 2'd0;
    localparam logic [1:0] MODE_IMPULSE = 2'd1;
    localparam logic [1:0] MODE_DC      = 2'd2;
    localparam logic [1:0] MODE_ALT     = 2'd3;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [DIV_W-1:0] div_cnt;
    logic [PH_W-1:0]  phase;
    logic [5:0]       sym_cnt;
    logic [14:0]      lfsr;
    logic [1:0]       active_mode;

    // ------------------------------------------------------------------
    // Combinational decode
    // ------------------------------------------------------------------
    logic               tick;
    logic               sym_tick;
    logic               mode_change;
    logic [1:0]         eff_mode;
    logic [5:0]         eff_cnt;
    logic [14:0]        lfsr_next;
    logic signed [17:0] prbs_level;
    logic signed [17:0] next_sample;

    always_comb begin
        tick        = (div_cnt == DIV_MAX);
        sym_tick    = tick && (phase == '0);
        mode_change = sym_tick && (mode != active_mode);

        // A new mode is only picked up on a symbol boundary, and it governs
        // that very sample; a change also restarts the symbol count there.
        eff_mode    = sym_tick ? mode : active_mode;
        eff_cnt     = mode_change ? 6'd0 : sym_cnt;

        lfsr_next   = {lfsr[13:0], lfsr[14] ^ lfsr[13]};
    end

    // Gray mapping of the two symbol bits onto the 4 PAM levels.
    always_comb begin
        prbs_level = NEG_3A;
        case (lfsr[1:0])
            2'b00:   prbs_level = NEG_3A;
            2'b01:   prbs_level = NEG_A;
            2'b11:   prbs_level = POS_A;
            2'b10:   prbs_level = POS_3A;
            default: prbs_level = NEG_3A;
        endcase
    end

    // Sample selection. Off-symbol phases are zero-stuffed except in DC mode,
    // which holds +a on every sample so the filter sees a true constant.
    always_comb begin
        next_sample = ZERO;
        case (eff_mode)
            MODE_PRBS: begin
                if (sym_tick) begin
                    next_sample = prbs_level;
                end
            end
            MODE_IMPULSE: begin
                if (sym_tick && (eff_cnt == 6'd0)) begin
                    next_sample = FULL;
                end
            end
            MODE_DC: begin
                next_sample = POS_A;
            end
            MODE_ALT: begin
                if (sym_tick) begin
                    next_sample = eff_cnt[0] ? NEG_3A : POS_3A;
                end
            end
            default: begin
                next_sample = ZERO;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Timing chain: clock divider and sample phase
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt <= '0;
            phase   <= '0;
        end else begin
            if (tick) begin
                div_cnt <= '0;
                phase   <= (phase == PH_MAX) ? '0 : phase + 1'b1;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Symbol-rate state: mode, symbol counter, PRBS
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            active_mode <= MODE_PRBS;
            sym_cnt     <= 6'd0;
            lfsr        <= LFSR_SEED;
        end else if (sym_tick) begin
            active_mode <= mode;
            sym_cnt     <= eff_cnt + 6'd1;
            // The PRBS runs in every mode so the sequence position does not
            // depend on how long a debug mode was selected.
            lfsr        <= lfsr_next;
        end
    end

    // ------------------------------------------------------------------
    // Output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            x_out        <= ZERO;
            sample_valid <= 1'b0;
            sym_strobe   <= 1'b0;
            sym_bits     <= 2'b00;
        end else begin
            sample_valid <= tick;
            sym_strobe   <= sym_tick;
            if (tick) begin
                x_out <= next_sample;
            end
            if (sym_tick) begin
                sym_bits <= lfsr[1:0];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_symbol_upsampler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_symbol_upsampler
//  Description : Self-checking bench for symbol_upsampler. Three instances:
//                defaults (main stream), CLK_PER_SAMP=3 (divider) and SPS=2
//                (full PRBS period check).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_symbol_upsampler;

    localparam int A = 21845;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance 1: default parameters
    logic               rst1;
    logic [1:0]         mode1;
    logic signed [17:0] x1;
    logic               v1, s1;
    logic [1:0]         b1;

    // Instance 3: CLK_PER_SAMP = 3
    logic               rst3;
    logic [1:0]         mode3;
    logic signed [17:0] x3;
    logic               v3, s3;
    logic [1:0]         b3;

    // Instance 2: SPS = 2, long PRBS run
    logic               rst2;
    logic [1:0]         mode2;
    logic signed [17:0] x2;
    logic               v2, s2;
    logic [1:0]         b2;

    symbol_upsampler #(.CLK_PER_SAMP(1), .SPS(4), .AMP(18'sd21845)) dut1 (
        .clk(clk), .reset(rst1), .mode(mode1),
        .x_out(x1), .sample_valid(v1), .sym_strobe(s1), .sym_bits(b1)
    );

    symbol_upsampler #(.CLK_PER_SAMP(3), .SPS(4), .AMP(18'sd21845)) dut3 (
        .clk(clk), .reset(rst3), .mode(mode3),
        .x_out(x3), .sample_valid(v3), .sym_strobe(s3), .sym_bits(b3)
    );

    symbol_upsampler #(.CLK_PER_SAMP(1), .SPS(2), .AMP(18'sd21845)) dut2 (
        .clk(clk), .reset(rst2), .mode(mode2),
        .x_out(x2), .sample_valid(v2), .sym_strobe(s2), .sym_bits(b2)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic signed [39:0] obs,
                       input logic signed [39:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Gray bits -> level index 0..3 -> odd multiple of a.
    function automatic int level(input logic [1:0] b);
        int v;
        v = {b[1], b[1] ^ b[0]};
        return (2 * v - 3) * A;
    endfunction

    // ------------------------------------------------------------------
    // Reference model for instance 1 (one tick per clock, 4 samples/symbol)
    // ------------------------------------------------------------------
    int          m_t;      // ticks since reset
    logic [14:0] m_lfsr;
    logic [1:0]  m_mode;
    int          m_cnt;    // symbols since reset / last mode change
    int          e_x;
    logic        e_v, e_s;
    logic [1:0]  e_b;

    task automatic model_update(input logic r, input logic [1:0] md);
        if (r) begin
            m_t = 0; m_lfsr = 15'h0001; m_mode = 2'd0; m_cnt = 0;
            e_x = 0; e_v = 1'b0; e_s = 1'b0; e_b = 2'b00;
        end else begin
            e_v = 1'b1;
            e_s = ((m_t % 4) == 0);
            if (e_s) begin
                if (md != m_mode) begin
                    m_mode = md;
                    m_cnt  = 0;
                end
                e_b = m_lfsr[1:0];
                case (m_mode)
                    2'd0:    e_x = level(e_b);
                    2'd1:    e_x = (m_cnt == 0) ? 131071 : 0;
                    2'd2:    e_x = A;
                    default: e_x = (m_cnt % 2 == 1) ? -3 * A : 3 * A;
                endcase
                m_cnt  = (m_cnt + 1) % 64;
                m_lfsr = {m_lfsr[13:0], m_lfsr[14] ^ m_lfsr[13]};
            end else begin
                e_x = (m_mode == 2'd2) ? A : 0;
            end
            m_t++;
        end
    endtask

    // One clock: drive inputs, let one rising edge pass, check at negedge.
    task automatic step(input logic r, input logic [1:0] md);
        rst1  = r;
        mode1 = md;
        @(negedge clk);
        model_update(r, md);
        chk("x_out", x1, e_x);
        chk("sample_valid", v1, e_v);
        chk("sym_strobe", s1, e_s);
        chk("sym_bits", b1, e_b);
    endtask

    // ------------------------------------------------------------------
    // Scoreboard for instance 2: every symbol sample must equal the Gray
    // mapping of its bits, and the bits must follow the PRBS.
    // ------------------------------------------------------------------
    logic [14:0] sw_lfsr = 15'h0001;
    int          sym_seen2 = 0;

    always @(negedge clk) begin
        if (!rst2 && s2) begin
            chk("long_map", x2, level(b2));
            chk("long_bits", b2, sw_lfsr[1:0]);
            sw_lfsr = {sw_lfsr[13:0], sw_lfsr[14] ^ sw_lfsr[13]};
            sym_seen2++;
        end
    end

    int          start_exp [9] = '{-21845, 0, 0, 0, 65535, 0, 0, 0, -65535};
    logic [1:0]  bits_exp  [3] = '{2'b01, 2'b10, 2'b00};

    initial begin
        logic [1:0] md;
        logic       r;
        int         prev3;
        int         budget;

        rst2 = 1'b1; mode2 = 2'd0;
        rst3 = 1'b1; mode3 = 2'd0;
        rst1 = 1'b1; mode1 = 2'd0;

        // PRBS start-up after a 3-cycle reset
        repeat (3) step(1'b1, 2'd0);
        chk("reset_x", x1, 0);
        chk("reset_valid", v1, 0);
        rst2 = 1'b0;
        for (int k = 0; k < 9; k++) begin
            step(1'b0, 2'd0);
            chk("startup_x", x1, start_exp[k]);
            if (k % 4 == 0) chk("startup_bits", b1, bits_exp[k / 4]);
        end

        // Reset mid-stream in symbol 10, phase 1
        while (m_t < 41) step(1'b0, 2'd0);
        step(1'b1, 2'd0);
        chk("midreset_x", x1, 0);
        chk("midreset_valid", v1, 0);
        chk("midreset_strobe", s1, 0);
        chk("midreset_bits", b1, 0);
        step(1'b0, 2'd0);
        chk("restart_x", x1, -21845);

        // Impulse train: 131071 every 256 samples
        step(1'b1, 2'd1);
        for (int i = 0; i < 600; i++) begin
            step(1'b0, 2'd1);
            chk("impulse", x1, (i % 256 == 0) ? 131071 : 0);
        end

        // Mode 0 -> 2 requested at phase 2, applied at next phase 0
        step(1'b1, 2'd0);
        repeat (10) step(1'b0, 2'd0);
        step(1'b0, 2'd2);
        chk("switch_ignored", x1, 0);
        step(1'b0, 2'd2);
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 2'd2);
            chk("dc_x", x1, A);
            chk("dc_sym_cnt", dut1.sym_cnt, m_cnt);
        end

        // Randomised modes with occasional resets
        md = 2'd0;
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 15) == 0) md = 2'($urandom_range(0, 3));
            r = ($urandom_range(0, 299) == 0);
            step(r, md);
        end

        // Divider: CLK_PER_SAMP = 3
        rst3 = 1'b1;
        repeat (2) step(1'b0, md);
        rst3 = 1'b0;
        prev3 = 0;
        for (int k = 1; k <= 30; k++) begin
            step(1'b0, md);
            chk("div_valid", v3, (k % 3 == 0));
            if (k % 3 == 0) begin
                chk("div_x", x3, start_exp[k / 3 - 1]);
                prev3 = x3;
            end else begin
                chk("div_hold", x3, prev3);
            end
            if (k / 3 == 9) break;
        end

        // Long run: full PRBS period on the SPS=2 instance
        budget = 70000;
        while (sym_seen2 < 32767 && budget > 0) begin
            step(1'b0, md);
            budget--;
        end
        chk("long_done", (sym_seen2 >= 32767), 1);
        chk("lfsr_period", dut2.lfsr, 15'h0001);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/symbol_upsampler.md
# symbol_upsampler

Test-stimulus source that sits directly upstream of the brick-wall FIR. It generates a 4-level pulse-amplitude symbol stream from an on-chip PRBS and upsamples it by zero-insertion. It outputs 18-bit 1s17 samples for the filter's `x_in`, along with a sample-valid strobe and symbol markers for downstream checkers. Alternate debug modes supply an impulse train, DC, and an alternating-sign pattern.

## Interface
- `CLK_PER_SAMP`, default 1: clocks per output sample, ≥1.
- `SPS`, default 4: samples per symbol (upsample factor), ≥2.
- `AMP`, default 18'sd21845: inner level `a` (≈1/6 in 1s17); outer level is `3*AMP`.
- `clk`, input, 1: system clock; all state on rising edge.
- `reset`, input, 1: synchronous, active-high.
- `mode`, input, 2: 0 PRBS 4-ASK, 1 impulse train, 2 DC, 3 alternating ±3a.
- `x_out`, output, 18 signed: sample to the FIR `x_in`; registered.
- `sample_valid`, output, 1: one-clock pulse whenever `x_out` takes a new value.
- `sym_strobe`, output, 1: high with `sample_valid` on phase-0 (symbol) samples.
- `sym_bits`, output, 2: LFSR bits that produced the current symbol; valid with `sym_strobe`.

## Operation
- **Divider.** `div_cnt` counts 0..`CLK_PER_SAMP`-1. A tick occurs on the edge where `div_cnt`==`CLK_PER_SAMP`-1. With the default, every clock is a tick.
- **Phase counter.** `phase` counts 0..`SPS`-1, advancing and wrapping on each tick.
- **Symbol counter.** `sym_cnt` is 6 bits, increments on each phase-0 tick, and wraps 63→0.
- **LFSR.** 15-bit, seed 15'h0001.
  - Advances once per phase-0 tick in every mode: next = {lfsr[14:0]... lfsr[13:0], lfsr[14]^lfsr[13]}.
  - Symbol bits are lfsr[1:0] taken before the shift.
- **PRBS mapping (Gray):** 00→-3a, 01→-a, 11→+a, 10→+3a.
- **Per-mode output on a phase-0 tick:**
  - Mode 0: the mapped symbol.
  - Mode 1: 18'sd131071 if `sym_cnt`==0, else 0.
  - Mode 2: +a.
  - Mode 3: +3a on even `sym_cnt`, -3a on odd.
- **Other phases:** `x_out`=0 (zero insertion) in modes 0, 1 and 3. Mode 2 outputs +a on every tick.
- **Mode changes.** `mode` is sampled only on phase-0 ticks.
  - A change applied there takes effect on that same sample.
  - Applying a change also clears `sym_cnt` to 0.
  - A change mid-symbol is ignored until the next phase 0.
- **Arithmetic.** ±3a is computed as an 18-bit signed constant. The parameter must satisfy 3*`AMP` ≤ 131071. No runtime saturation is needed.
- **Reset values.** `x_out`=0, `sample_valid`=0, `sym_strobe`=0, `sym_bits`=0, `div_cnt`=0, `phase`=0, `sym_cnt`=0, lfsr=15'h0001, active mode=0.
- **Reset mid-operation.** All state returns to the reset values on the next edge. The first tick after reset is always phase 0 with the seed state.

## Timing
- **Latency.** Outputs are registered on the tick edge and visible the following cycle. `sample_valid` is high for exactly that one cycle.
- **First tick after reset.** Occurs `CLK_PER_SAMP` edges after the edge on which `reset` is sampled low.
- **Default parameters.** `sample_valid` is continuously high from the first edge after reset release. `sym_strobe` is high on 1 of every 4 cycles.
- **Hold between ticks.** `x_out` holds its value.
- **Period.** The PRBS has period 32767 symbols.

## Test plan
- **PRBS start-up.** Reset for 3 cycles, mode=0, defaults → `x_out` = -21845, 0, 0, 0, 65535, 0, 0, 0, -65535. `sym_bits` 01, 10, 00 on the strobes.
- **Impulse mode.** mode=1 → 131071 on the first symbol, then zeros for 255 samples; repeats every 256 samples. `sym_strobe` every 4th sample.
- **Mid-symbol mode switch.** Switch mode 0→2 at phase 2 → change applied at the next phase 0. From then, `x_out`=21845 on every sample and `sym_cnt` restarts at 0.
- **Divider.** `CLK_PER_SAMP`=3 → `sample_valid` one cycle in three. `x_out` is constant between pulses. Sequence matches the first test.
- **Reset mid-stream.** Assert reset during symbol 10, phase 1 → next cycle all outputs 0. After release, the sequence restarts at -21845.
- **Long run.** Mode 0 for 32767 symbols → the LFSR returns to 15'h0001. A scoreboard comparison of `x_out` against `sym_bits` mapping shows zero mismatches.
